// File: rtl/lab3_d_ff_gatelevel.sv
`timescale 1ns/1ps
// lab3_d_ff_gatelevel
// Positive-edge-triggered D flip-flop built purely from gate primitives.
// Each bit slice is the classic 6-NAND edge-triggered structure: two input
// latches steer an SR output latch. Reset is folded into the data path
// (D AND Rst_n), so it only acts at a rising edge and never touches the
// internal set/clear nodes directly. Q and Qb are undefined until the first
// rising Clk edge captures a value.
module lab3_d_ff_gatelevel #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] D,
    input  logic             Clk,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    input  logic             Rst_n
);

    // One independent flip-flop slice per bit; all slices share Clk and Rst_n.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic d_eff;
            logic hold_n;
            logic set_n;
            logic clr_n;
            logic data_n;

            // Gating D with Rst_n turns an asserted reset into "capture 0".
            and  u_d_eff  (d_eff, D[i], Rst_n);

            // While Clk is low, set_n and clr_n are both held high and the
            // input latches track d_eff. On the rising edge exactly one of
            // them drops low and locks the input latches until Clk falls.
            nand u_hold   (hold_n, data_n, set_n);
            nand u_set    (set_n, hold_n, Clk);
            nand u_clr    (clr_n, set_n, Clk, data_n);
            nand u_data   (data_n, clr_n, d_eff);

            // SR output latch driven by the active-low set/clear pulses.
            nand u_q      (Q[i], set_n, Qb[i]);
            nand u_qb     (Qb[i], clr_n, Q[i]);
        end
    endgenerate

endmodule

// File: tb/tb_lab3_d_ff_gatelevel.sv
`timescale 1ns/1ps
// tb_lab3_d_ff_gatelevel
// Scoreboard bench for the gate-level D flip-flop (4-bit instance).
// A reference model records the value every rising edge should capture and
// queues it; a monitor pops one entry 1 ns after each rising edge and
// compares Q and Qb. A strobe process also checks the held value at every
// half-nanosecond point between edges so glitches and falling-edge changes
// are caught.
module tb_lab3_d_ff_gatelevel;

    localparam int WIDTH = 4;
    localparam int RANDOM_CYCLES = 200;

    logic [WIDTH-1:0] d;
    logic             clk;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             rst_n;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_queue[$];
    logic [WIDTH-1:0] cur_q;

    lab3_d_ff_gatelevel #(.WIDTH(WIDTH)) dut (
        .D     (d),
        .Clk   (clk),
        .Q     (q),
        .Qb    (qb),
        .Rst_n (rst_n)
    );

    // Clock: period 10 ns, starts low, rises at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name,
                               input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Drive D and Rst_n at an absolute time (ns), always away from an edge.
    task automatic applyStimulus(input int at_ns,
                                 input logic [WIDTH-1:0] dv,
                                 input logic rv);
        if (longint'(at_ns) > longint'($time))
            #(longint'(at_ns) - longint'($time));
        d     = dv;
        rst_n = rv;
    endtask

    // Reference model: a rising edge stores D when reset is released, zero otherwise.
    always @(posedge clk) begin
        logic [WIDTH-1:0] expect_val;
        expect_val = rst_n ? d : '0;
        exp_queue.push_back(expect_val);
        cur_q = expect_val;
    end

    // Monitor: 1 ns after each rising edge, pop the expected capture and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_queue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_queue.pop_front();
                checkOutput("q_edge", q, e);
                checkOutput("qb_edge", qb, ~e);
            end
        end
    end

    // Strobe between edges: Q must hold the last captured value, Qb its complement.
    initial begin
        #5.5;
        forever begin
            checkOutput("q_hold", q, cur_q);
            checkOutput("qb_hold", qb, ~cur_q);
            #1;
        end
    end

    initial begin
        $display("[TB] starting gate-level D flip-flop bench, WIDTH=%0d", WIDTH);

        // Power-up with reset held and D=1 for three edges (5, 15, 25): Q must be 0.
        applyStimulus(0,   4'hF, 1'b0);

        // Release reset, then the reference D waveform shifted by 30 ns.
        // Edges 35..125 expect 0,1,0,0,1,0,1,1,1,1; glitch 0@107/1@111 is ignored.
        applyStimulus(27,  4'h0, 1'b1);
        applyStimulus(37,  4'hF, 1'b1);
        applyStimulus(47,  4'h0, 1'b1);
        applyStimulus(67,  4'hF, 1'b1);
        applyStimulus(77,  4'h0, 1'b1);
        applyStimulus(87,  4'hF, 1'b1);
        applyStimulus(107, 4'h0, 1'b1);
        applyStimulus(111, 4'hF, 1'b1);

        // Synchronous reset between edges: no effect until 135, released before 145.
        applyStimulus(132, 4'hF, 1'b0);
        applyStimulus(138, 4'hF, 1'b1);

        // Multi-bit patterns: 1010 captured at 155, then reset wins over 0110 at 165.
        applyStimulus(147, 4'b1010, 1'b1);
        applyStimulus(157, 4'b0110, 1'b0);
        applyStimulus(167, 4'b0110, 1'b1);

        // Randomized cycles with mid-cycle glitches on D and random reset.
        for (int k = 0; k < RANDOM_CYCLES; k++) begin
            int base;
            base = 175 + 10 * k;
            applyStimulus(base + 2, WIDTH'($urandom), ($urandom_range(3) != 0));
            applyStimulus(base + 4, WIDTH'($urandom), rst_n);
            applyStimulus(base + 7, WIDTH'($urandom), ($urandom_range(3) != 0));
        end

        // Let the last captures drain through the monitor.
        applyStimulus(175 + 10 * RANDOM_CYCLES + 12, d, rst_n);

        if (exp_queue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", exp_queue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
